result_bit_ram: RTL and testbench
=================================

RESULT_BIT_RAM -- requirements
Module: result_bit_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning read word width in bits (power of two, 8..64).
REQ-002 SHALL have parameter ADDR_W, default 20, meaning bit-address width; capacity is 2^ADDR_W bits.
REQ-003 SHALL have parameter READ_LAT, default 1, meaning read latency in cycles (1 or 2).
REQ-004 SHALL have port clk  input  1  meaning the single clock for all logic.
REQ-005 SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have ports wea/web  input  1  meaning port A/B bit-write enable.
REQ-007 SHALL have ports addra/addrb  input  ADDR_W  meaning port A/B bit address.
REQ-008 SHALL have ports dina/dinb  input  1  meaning port A/B write bit.
REQ-009 SHALL have ports douta/doutb  output  DATA_W  meaning port A/B read word.
REQ-010 SHALL have port clear_start  input  1  meaning single-cycle pulse that starts a zero sweep.
REQ-011 SHALL have port clear_busy  output  1  meaning a sweep is in progress.
REQ-012 SHALL have port clear_done  output  1  meaning one-cycle pulse when the sweep completes.
REQ-013 SHALL have port wr_dropped  output  1  meaning sticky flag: a write arrived during a sweep.

Function
REQ-014 SHALL store 2^(ADDR_W-log2(DATA_W)) words of DATA_W bits; word index = addr[ADDR_W-1:log2(DATA_W)], bit index = addr[log2(DATA_W)-1:0].
REQ-015 SHALL, on we=1 outside a sweep, update only the addressed bit, leaving the other DATA_W-1 bits unchanged.
REQ-016 SHALL present on dout the word containing the addressed bit READ_LAT cycles after addr is sampled, on every cycle regardless of we.
REQ-017 SHALL read-first: a read and a write to the same word in one cycle return the pre-write word.
REQ-018 SHALL apply both writes when A and B write different bits of the same word in one cycle.
REQ-019 SHALL let port A win when A and B write the same bit in one cycle.
REQ-020 SHALL implement FSM states IDLE, SWEEP and DONE: IDLE->SWEEP on clear_start; SWEEP writes zero to one word per cycle at ascending index 0..last; SWEEP->DONE after the last word; DONE->IDLE after one cycle.
REQ-021 SHALL assert clear_busy in SWEEP only; clear_done is high in DONE only; a sweep takes exactly 2^(ADDR_W-log2(DATA_W)) busy cycles.
REQ-022 SHALL ignore clear_start outside IDLE, with no restart.
REQ-023 SHALL drop port writes while clear_busy=1 and set wr_dropped; wr_dropped clears on the clear_start that is accepted.
REQ-024 SHALL force douta/doutb to zero for reads sampled while clear_busy=1.
REQ-025 SHALL wrap the sweep counter to 0 only through reset or a new accepted clear_start.

Reset
REQ-026 SHALL, while reset=1, hold FSM=IDLE, sweep counter=0, clear_busy=0, clear_done=0, wr_dropped=0, douta=doutb=0 and all read pipeline registers=0.
REQ-027 SHALL abort a sweep on reset mid-sweep without producing clear_done; memory contents are undefined until the next complete sweep.
REQ-028 SHALL not reset memory contents.

Structure
REQ-029 SHALL place the FSM state enum and the derived constants WORD_IDX_W=ADDR_W-log2(DATA_W) and BIT_IDX_W=log2(DATA_W) in the shared package result_mem_pkg.
REQ-030 SHALL isolate storage in one sub-module, result_bit_ram_core: a dual-port, per-bit write-enable, read-first RAM inferable as block RAM.
REQ-031 SHALL keep the sweep FSM, write arbitration and read latency pipeline in result_bit_ram.

Verification
REQ-032 Sweep with DATA_W=32, ADDR_W=10: clear_start -> clear_busy high for 32 cycles, one clear_done pulse, then all words read as 0x00000000.
REQ-033 Bit write and read: wea at addra=0x005 with dina=1, then read addra=0x000 -> douta=0x00000020 after READ_LAT cycles.
REQ-034 Dual write, same word: wea addra=0x040 dina=1 with web addrb=0x05F dinb=1 -> word 2 reads 0x80000001.
REQ-035 Same-bit collision: A writes bit 0x003 with 1 while B writes bit 0x003 with 0 -> bit reads 1; a same-cycle read returns the old word.
REQ-036 Write during sweep: wea pulse at cycle 5 of a sweep -> write lost, wr_dropped=1 until the next clear_start.
REQ-037 Reset mid-sweep at cycle 10 -> clear_busy=0 immediately, no clear_done; a new clear_start runs a full 32-cycle sweep.

Source files
------------

// File: rtl/result_mem_pkg.sv
// Shared types and width helpers for the bit-addressable result RAM.
package result_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 20;
  localparam int BIT_IDX_W  = $clog2(DEF_DATA_W);
  localparam int WORD_IDX_W = DEF_ADDR_W - BIT_IDX_W;

  // Same derivations for any parameterisation of the RAM.
  function automatic int bit_idx_w(input int data_w);
    return $clog2(data_w);
  endfunction

  function automatic int word_idx_w(input int addr_w, input int data_w);
    return addr_w - $clog2(data_w);
  endfunction

endpackage

// File: rtl/result_bit_ram_core.sv
// Dual-port word RAM with per-bit write mask and registered read-first output.
// Same-word writes on both ports are merged upstream, so the ports never collide here.
module result_bit_ram_core #(
  parameter int DATA_W  = 32,
  parameter int WORDS_W = 15
) (
  input  logic               clk,
  input  logic [WORDS_W-1:0] i_addr_a,
  input  logic [DATA_W-1:0]  i_wmask_a,
  input  logic [DATA_W-1:0]  i_wdat_a,
  output logic [DATA_W-1:0]  o_rdat_a,
  input  logic [WORDS_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0]  i_wmask_b,
  input  logic [DATA_W-1:0]  i_wdat_b,
  output logic [DATA_W-1:0]  o_rdat_b
);

  logic [DATA_W-1:0] r_mem [0:(1<<WORDS_W)-1];
  logic [DATA_W-1:0] r_rdat_a;
  logic [DATA_W-1:0] r_rdat_b;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W; i++) begin
      if (i_wmask_b[i]) r_mem[i_addr_b][i] <= i_wdat_b[i];
      if (i_wmask_a[i]) r_mem[i_addr_a][i] <= i_wdat_a[i];
    end
    r_rdat_a <= r_mem[i_addr_a];
    r_rdat_b <= r_mem[i_addr_b];
  end

  assign o_rdat_a = r_rdat_a;
  assign o_rdat_b = r_rdat_b;

endmodule

// File: rtl/result_bit_ram.sv
// Bit-write / word-read result RAM with a zero-sweep engine; reads take READ_LAT cycles.
// Port writes are dropped (and flagged) while a sweep owns port A.
module result_bit_ram #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 20,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wea,
  input  logic              web,
  input  logic [ADDR_W-1:0] addra,
  input  logic [ADDR_W-1:0] addrb,
  input  logic              dina,
  input  logic              dinb,
  output logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] doutb,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              wr_dropped
);

  import result_mem_pkg::*;

  localparam int BIT_W  = bit_idx_w(DATA_W);
  localparam int WORD_W = word_idx_w(ADDR_W, DATA_W);
  localparam logic [WORD_W-1:0] LAST_IDX = '1;
  localparam logic [DATA_W-1:0] ONE_BIT  = {{(DATA_W-1){1'b0}}, 1'b1};

  sweep_state_e r_state;
  sweep_state_e w_state_nxt;
  logic [WORD_W-1:0] r_sweep_idx;
  logic              r_wr_dropped;
  logic              r_rd_vld;
  logic              w_busy;
  logic              w_done;
  logic              w_start_ok;

  logic [WORD_W-1:0] w_word_a, w_word_b, w_ram_addr_a;
  logic [BIT_W-1:0]  w_bit_a, w_bit_b;
  logic [DATA_W-1:0] w_onehot_a, w_onehot_b;
  logic [DATA_W-1:0] w_mask_a, w_wdat_a, w_mask_b, w_wdat_b;
  logic [DATA_W-1:0] w_ram_rdat_a, w_ram_rdat_b, w_rd_a, w_rd_b;

  assign w_start_ok = (r_state == ST_IDLE) && clear_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (clear_start) w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (r_sweep_idx == LAST_IDX) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_SWEEP: w_busy = 1'b1;
      ST_DONE:  w_done = 1'b1;
      default:  ;
    endcase
  end

  // The counter parks on the last word; only a new sweep or reset returns it to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      r_sweep_idx <= '0;
    else if (w_start_ok)                            r_sweep_idx <= '0;
    else if (w_busy && (r_sweep_idx != LAST_IDX))   r_sweep_idx <= r_sweep_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_wr_dropped <= 1'b0;
    else if (w_start_ok)              r_wr_dropped <= 1'b0;
    else if (w_busy && (wea || web))  r_wr_dropped <= 1'b1;
  end

  assign w_word_a   = addra[ADDR_W-1:BIT_W];
  assign w_word_b   = addrb[ADDR_W-1:BIT_W];
  assign w_bit_a    = addra[BIT_W-1:0];
  assign w_bit_b    = addrb[BIT_W-1:0];
  assign w_onehot_a = ONE_BIT << w_bit_a;
  assign w_onehot_b = ONE_BIT << w_bit_b;

  // Same-word writes fold into port A; A's bit is applied last so A wins a same-bit clash.
  always_comb begin
    w_ram_addr_a = w_word_a;
    w_mask_a     = '0;
    w_wdat_a     = '0;
    w_mask_b     = '0;
    w_wdat_b     = '0;
    if (w_busy) begin
      w_ram_addr_a = r_sweep_idx;
      w_mask_a     = '1;
    end else begin
      if (web) begin
        if (wea && (w_word_a == w_word_b)) begin
          w_mask_a = w_onehot_b;
          w_wdat_a = {DATA_W{dinb}} & w_onehot_b;
        end else begin
          w_mask_b = w_onehot_b;
          w_wdat_b = {DATA_W{dinb}} & w_onehot_b;
        end
      end
      if (wea) begin
        w_mask_a = w_mask_a | w_onehot_a;
        w_wdat_a = (w_wdat_a & ~w_onehot_a) | ({DATA_W{dina}} & w_onehot_a);
      end
    end
  end

  result_bit_ram_core #(
    .DATA_W  (DATA_W),
    .WORDS_W (WORD_W)
  ) u_core (
    .clk       (clk),
    .i_addr_a  (w_ram_addr_a),
    .i_wmask_a (w_mask_a),
    .i_wdat_a  (w_wdat_a),
    .o_rdat_a  (w_ram_rdat_a),
    .i_addr_b  (w_word_b),
    .i_wmask_b (w_mask_b),
    .i_wdat_b  (w_wdat_b),
    .o_rdat_b  (w_ram_rdat_b)
  );

  // Marks reads sampled outside a sweep; also keeps outputs at zero through reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_vld <= 1'b0;
    else       r_rd_vld <= ~w_busy;
  end

  assign w_rd_a = r_rd_vld ? w_ram_rdat_a : '0;
  assign w_rd_b = r_rd_vld ? w_ram_rdat_b : '0;

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] r_dout_a;
      logic [DATA_W-1:0] r_dout_b;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_dout_a <= '0;
          r_dout_b <= '0;
        end else begin
          r_dout_a <= w_rd_a;
          r_dout_b <= w_rd_b;
        end
      end
      assign douta = r_dout_a;
      assign doutb = r_dout_b;
    end else begin : g_lat1
      assign douta = w_rd_a;
      assign doutb = w_rd_b;
    end
  endgenerate

  assign clear_busy = w_busy;
  assign clear_done = w_done;
  assign wr_dropped = r_wr_dropped;

endmodule

// File: tb/tb_result_bit_ram.sv
// Bench for result_bit_ram: READ_LAT=1 and READ_LAT=2 instances share stimulus;
// a behavioural model feeds a read scoreboard, scenario tasks check control behaviour.
module tb_result_bit_ram;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, wea, web, dina, dinb, clear_start;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] douta1, doutb1, douta2, doutb2;
  logic          busy1, done1, drop1, busy2, done2, drop2;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    bit            ca;
    bit            cb;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  logic [DW-1:0] m_mem [NW];
  bit            m_known [NW];
  int            m_state;
  int            m_idx;
  bit            m_drop;

  result_bit_ram #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
    .dina(dina), .dinb(dinb), .douta(douta1), .doutb(doutb1), .clear_start(clear_start),
    .clear_busy(busy1), .clear_done(done1), .wr_dropped(drop1)
  );

  result_bit_ram #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
    .dina(dina), .dinb(dinb), .douta(douta2), .doutb(doutb2), .clear_start(clear_start),
    .clear_busy(busy2), .clear_done(done2), .wr_dropped(drop2)
  );

  task automatic reset_model();
    m_state = 0;
    m_idx   = 0;
    m_drop  = 0;
    q1.delete();
    q2.delete();
    for (int i = 0; i < NW; i++) m_known[i] = 0;
  endtask

  // One clock: predict reads, update the model, advance, then score the DUT outputs.
  task automatic step();
    exp_t     e;
    int       wa, wb, ba, bb;
    logic [2:0] exp_ctl;
    wa = int'(addra[AW-1:5]);
    wb = int'(addrb[AW-1:5]);
    ba = int'(addra[4:0]);
    bb = int'(addrb[4:0]);
    e.ca = (m_state == 1) || m_known[wa];
    e.cb = (m_state == 1) || m_known[wb];
    e.a  = (m_state == 1) ? '0 : m_mem[wa];
    e.b  = (m_state == 1) ? '0 : m_mem[wb];
    q1.push_back(e);
    q2.push_back(e);
    if (m_state == 1) begin
      m_mem[m_idx]   = '0;
      m_known[m_idx] = 1;
      if (wea || web) m_drop = 1;
    end else begin
      if (web) m_mem[wb][bb] = dinb;
      if (wea) m_mem[wa][ba] = dina;
    end
    case (m_state)
      0: if (clear_start) begin m_state = 1; m_idx = 0; m_drop = 0; end
      1: if (m_idx == NW - 1) m_state = 2; else m_idx++;
      default: m_state = 0;
    endcase
    @(posedge clk);
    #1;
    e = q1.pop_front();
    if (e.ca) begin
      n_checks++;
      if (douta1 !== e.a) begin n_errors++; $display("FAIL sb_douta_lat1 got %h exp %h", douta1, e.a); end
    end
    if (e.cb) begin
      n_checks++;
      if (doutb1 !== e.b) begin n_errors++; $display("FAIL sb_doutb_lat1 got %h exp %h", doutb1, e.b); end
    end
    if (q2.size() == 2) begin
      e = q2.pop_front();
      if (e.ca) begin
        n_checks++;
        if (douta2 !== e.a) begin n_errors++; $display("FAIL sb_douta_lat2 got %h exp %h", douta2, e.a); end
      end
      if (e.cb) begin
        n_checks++;
        if (doutb2 !== e.b) begin n_errors++; $display("FAIL sb_doutb_lat2 got %h exp %h", doutb2, e.b); end
      end
    end
    exp_ctl = {m_state == 1, m_state == 2, m_drop};
    n_checks++;
    if ({busy1, done1, drop1, busy2, done2, drop2} !== {exp_ctl, exp_ctl}) begin
      n_errors++;
      $display("FAIL sb_ctl got %b%b%b/%b%b%b exp %b", busy1, done1, drop1, busy2, done2, drop2, exp_ctl);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({douta1, doutb1, douta2, doutb2} !== '0) begin
      n_errors++; $display("FAIL reset_dout got %h %h %h %h exp 0", douta1, doutb1, douta2, doutb2);
    end
    n_checks++;
    if ({busy1, done1, drop1, busy2, done2, drop2} !== 6'b0) begin
      n_errors++; $display("FAIL reset_ctl got %b%b%b%b%b%b exp 000000", busy1, done1, drop1, busy2, done2, drop2);
    end
    reset = 1'b0;
    reset_model();
    step();
    n_checks++;
    if (busy1 !== 1'b0) begin n_errors++; $display("FAIL reset_idle_busy got %b exp 0", busy1); end
  endtask

  task automatic test_sweep();
    int nbusy, ndone;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    n_checks++;
    if (busy1 !== 1'b1) begin n_errors++; $display("FAIL sweep_busy_start got %b exp 1", busy1); end
    nbusy = 1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy1) nbusy++;
      if (done1) ndone++;
    end
    n_checks++;
    if (nbusy != 32) begin n_errors++; $display("FAIL sweep_busy_cycles got %0d exp 32", nbusy); end
    n_checks++;
    if (ndone != 1) begin n_errors++; $display("FAIL sweep_done_pulses got %0d exp 1", ndone); end
    for (int w = 0; w < NW; w++) begin
      addra = AW'(w * DW);
      addrb = AW'(w * DW + 31);
      step();
      n_checks++;
      if (douta1 !== 32'h0) begin n_errors++; $display("FAIL sweep_zero_w%0d got %h exp 0", w, douta1); end
    end
  endtask

  task automatic test_bit_write();
    addra = AW'(5); dina = 1'b1; wea = 1'b1;
    step();
    wea = 1'b0; addra = '0; addrb = '0;
    step();
    n_checks++;
    if (douta1 !== 32'h0000_0020) begin n_errors++; $display("FAIL bitwr_douta got %h exp 00000020", douta1); end
    n_checks++;
    if (doutb1 !== 32'h0000_0020) begin n_errors++; $display("FAIL bitwr_doutb got %h exp 00000020", doutb1); end
    step();
    n_checks++;
    if (douta2 !== 32'h0000_0020) begin n_errors++; $display("FAIL bitwr_lat2 got %h exp 00000020", douta2); end
  endtask

  task automatic test_dual_write();
    wea = 1'b1; addra = AW'('h040); dina = 1'b1;
    web = 1'b1; addrb = AW'('h05F); dinb = 1'b1;
    step();
    wea = 1'b0; web = 1'b0; addra = AW'('h041); addrb = AW'('h050);
    step();
    n_checks++;
    if (douta1 !== 32'h8000_0001) begin n_errors++; $display("FAIL dual_douta got %h exp 80000001", douta1); end
    n_checks++;
    if (doutb1 !== 32'h8000_0001) begin n_errors++; $display("FAIL dual_doutb got %h exp 80000001", doutb1); end
  endtask

  task automatic test_collision();
    wea = 1'b1; addra = AW'(3); dina = 1'b1;
    web = 1'b1; addrb = AW'(3); dinb = 1'b0;
    step();
    n_checks++;
    if (douta1 !== 32'h0000_0020) begin n_errors++; $display("FAIL coll_read_first got %h exp 00000020", douta1); end
    wea = 1'b0; web = 1'b0;
    step();
    n_checks++;
    if (douta1 !== 32'h0000_0028) begin n_errors++; $display("FAIL coll_a_wins1 got %h exp 00000028", douta1); end
    wea = 1'b1; dina = 1'b0; web = 1'b1; dinb = 1'b1;
    step();
    wea = 1'b0; web = 1'b0;
    step();
    n_checks++;
    if (douta1 !== 32'h0000_0020) begin n_errors++; $display("FAIL coll_a_wins0 got %h exp 00000020", douta1); end
  endtask

  task automatic test_write_during_sweep();
    int nbusy;
    n_checks++;
    if (drop1 !== 1'b0) begin n_errors++; $display("FAIL drop_initial got %b exp 0", drop1); end
    addra = AW'('h040);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    nbusy = 1;
    for (int i = 1; i < 32; i++) begin
      wea         = (i == 5);
      dina        = 1'b1;
      addra       = (i == 5) ? AW'(1) : AW'('h040);
      clear_start = (i == 7);
      step();
      if (busy1) nbusy++;
      if (i == 1) begin
        n_checks++;
        if (douta1 !== 32'h0) begin n_errors++; $display("FAIL sweep_read_forced got %h exp 0", douta1); end
      end
      if (i == 5) begin
        n_checks++;
        if (drop1 !== 1'b1) begin n_errors++; $display("FAIL drop_set got %b exp 1", drop1); end
      end
    end
    wea = 1'b0; clear_start = 1'b0;
    step();
    n_checks++;
    if (nbusy != 32 || done1 !== 1'b1) begin
      n_errors++; $display("FAIL sweep_no_restart got busy=%0d done=%b exp 32 1", nbusy, done1);
    end
    step();
    addra = '0;
    step();
    n_checks++;
    if (douta1 !== 32'h0 || drop1 !== 1'b1) begin
      n_errors++; $display("FAIL drop_write_lost got %h drop=%b exp 0 1", douta1, drop1);
    end
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    n_checks++;
    if (drop1 !== 1'b0) begin n_errors++; $display("FAIL drop_cleared got %b exp 0", drop1); end
    for (int i = 0; i < 34; i++) step();
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < 60; i++) begin
      addra = AW'($urandom_range(0, 1023));
      addrb = ($urandom_range(0, 1) == 1) ? {addra[AW-1:5], 5'($urandom_range(0, 31))}
                                          : AW'($urandom_range(0, 1023));
      wea  = 1'($urandom_range(0, 1));
      web  = 1'($urandom_range(0, 1));
      dina = 1'($urandom_range(0, 1));
      dinb = 1'($urandom_range(0, 1));
      step();
    end
    wea = 1'b0; web = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w = int'($urandom_range(0, NW - 1));
      addra = AW'(w * DW);
      step();
      n_checks++;
      if (douta1 !== m_mem[w]) begin n_errors++; $display("FAIL b2b_word%0d got %h exp %h", w, douta1, m_mem[w]); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int nbusy, ndone;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      n_errors++; $display("FAIL midrst_busy got %b %b exp 0 0", busy1, busy2);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done1 !== 1'b0 || done2 !== 1'b0) begin
      n_errors++; $display("FAIL midrst_done got %b %b exp 0 0", done1, done2);
    end
    reset = 1'b0;
    reset_model();
    step();
    n_checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      n_errors++; $display("FAIL midrst_after got done=%b busy=%b exp 0 0", done1, busy1);
    end
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    nbusy = busy1 ? 1 : 0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy1) nbusy++;
      if (done1) ndone++;
    end
    n_checks++;
    if (nbusy != 32 || ndone != 1) begin
      n_errors++; $display("FAIL midrst_resweep got busy=%0d done=%0d exp 32 1", nbusy, ndone);
    end
    for (int w = 0; w < NW; w++) begin
      addra = AW'(w * DW);
      addrb = AW'(w * DW + 7);
      step();
    end
    step();
  endtask

  initial begin
    reset = 1'b1; wea = 1'b0; web = 1'b0; dina = 1'b0; dinb = 1'b0;
    addra = '0; addrb = '0; clear_start = 1'b0;
    reset_model();
    test_reset();
    test_sweep();
    test_bit_write();
    test_dual_write();
    test_collision();
    test_write_during_sweep();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
